// File: rtl/fpga_cnn_pkg.sv
// ---------------------------------------------------------------------------
// fpga_cnn_pkg
// Shared definitions for the vector datapath (packer, VecMul, AddTree).
//  - DEFAULT_WIDTH  : bits per signed fixed-point operand
//  - DEFAULT_LENGTH : lanes per parallel vector
//  - LANE(k)        : part-select of lane k inside a flattened lane vector;
//                     expects a WIDTH parameter in the using scope
//  - count_width()  : width of a lane-count field able to hold 0..length
// ---------------------------------------------------------------------------
`ifndef FPGA_CNN_LANE_MACRO
`define FPGA_CNN_LANE_MACRO
`define LANE(k) (k)*WIDTH +: WIDTH
`endif

package fpga_cnn_pkg;

   localparam int DEFAULT_WIDTH  = 16;
   localparam int DEFAULT_LENGTH = 4;

   // A count of 0..length needs one more code than the lane index does.
   function automatic int count_width(input int length);
      return $clog2(length + 1);
   endfunction

endpackage

// File: rtl/vec_skid_reg.sv
// ---------------------------------------------------------------------------
// vec_skid_reg
// Single valid/ready register stage holding one packed vector payload.
// Ports:
//  clk, rst_n            clock, asynchronous active-low reset
//  in_valid / in_ready   upstream handshake (in_ready when empty or draining)
//  in_data  [W]          payload loaded on in_valid && in_ready
//  out_valid / out_ready downstream handshake
//  out_data [W]          held payload, stable until handed off
// ---------------------------------------------------------------------------
module vec_skid_reg
#(
   parameter int W = 8
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   // The stage can take a new payload whenever it is empty or its current
   // payload leaves on this same edge, so back-to-back vectors see no bubble.
   assign in_ready = !out_valid || out_ready;

   // Payload only changes on a load, which keeps it stable during a stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/vec_operand_packer.sv
// ---------------------------------------------------------------------------
// vec_operand_packer
// Packs a serial stream of signed operand pairs (a,b) into LENGTH-lane
// parallel vectors for VecMul/AddTree. A vector closes when its last lane is
// written or when in_last marks the end of an inner product; unused upper
// lanes are zero so they contribute nothing to the sum.
// Ports:
//  clk, rst_n              clock, asynchronous active-low reset
//  flush                   drop the partially packed vector
//  in_valid/in_ready       scalar pair handshake
//  in_a, in_b [WIDTH]      operands, passed bit-exact
//  in_last                 pair ends the current inner product
//  vec_valid/vec_ready     vector handshake towards VecMul
//  vec_a, vec_b [LENGTH*WIDTH]  lane k at LANE(k)
//  vec_count [CW]          populated lanes, 1..LENGTH
//  vec_last                vector closes an inner product
// ---------------------------------------------------------------------------
module vec_operand_packer
   import fpga_cnn_pkg::*;
#(
   parameter  int LENGTH = DEFAULT_LENGTH,
   parameter  int WIDTH  = DEFAULT_WIDTH,
   localparam int CW     = count_width(LENGTH)
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        in_a,
   input  logic [WIDTH-1:0]        in_b,
   input  logic                    in_last,
   output logic                    vec_valid,
   input  logic                    vec_ready,
   output logic [LENGTH*WIDTH-1:0] vec_a,
   output logic [LENGTH*WIDTH-1:0] vec_b,
   output logic [CW-1:0]           vec_count,
   output logic                    vec_last
);

   localparam int              PW        = $clog2(LENGTH);
   localparam int              VW        = LENGTH * WIDTH;
   localparam int              PAYLOAD_W = 2 * VW + CW + 1;
   localparam logic [PW-1:0]   LAST_PTR  = PW'(LENGTH - 1);

   logic [PW-1:0]        ptr;
   logic [VW-1:0]        pack_a;
   logic [VW-1:0]        pack_b;
   logic [CW-1:0]        pack_count;
   logic                 pack_last;
   logic                 pack_full;

   logic [VW-1:0]        close_a;
   logic [VW-1:0]        close_b;
   logic [CW-1:0]        close_count;
   logic                 accept;
   logic                 closing;

   logic                 out_push;
   logic                 out_room;
   logic [PAYLOAD_W-1:0] out_push_data;
   logic [PAYLOAD_W-1:0] out_data;

   // Flush wins over a same-cycle beat; a parked vector blocks new beats
   // until the output register has room for it.
   assign in_ready = !pack_full && !flush;
   assign accept   = in_valid && in_ready;
   assign closing  = accept && (ptr == LAST_PTR || in_last);

   // The vector as it looks once the current beat lands in lane ptr: lower
   // lanes come from the pack register and everything above ptr is zeroed.
   always_comb begin
      close_a     = '0;
      close_b     = '0;
      close_count = CW'(ptr) + CW'(1);
      for (int k = 0; k < LENGTH; k++) begin
         if (k < int'(ptr)) begin
            close_a[`LANE(k)] = pack_a[`LANE(k)];
            close_b[`LANE(k)] = pack_b[`LANE(k)];
         end else if (k == int'(ptr)) begin
            close_a[`LANE(k)] = in_a;
            close_b[`LANE(k)] = in_b;
         end
      end
   end

   // A parked vector has priority for the output register; otherwise a
   // closing beat goes straight through without first visiting the pack reg.
   always_comb begin
      out_push      = !flush && (pack_full || closing);
      out_push_data = pack_full ? {pack_a, pack_b, pack_count, pack_last}
                                : {close_a, close_b, close_count, in_last};
   end

   // Lane pointer and pack register. Lanes are cleared whenever a vector
   // leaves so the next partial vector starts from zeros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr        <= '0;
         pack_a     <= '0;
         pack_b     <= '0;
         pack_count <= '0;
         pack_last  <= 1'b0;
         pack_full  <= 1'b0;
      end else if (flush) begin
         ptr       <= '0;
         pack_a    <= '0;
         pack_b    <= '0;
         pack_full <= 1'b0;
      end else if (pack_full) begin
         if (out_room) begin
            pack_full <= 1'b0;
            pack_a    <= '0;
            pack_b    <= '0;
         end
      end else if (accept) begin
         if (closing) begin
            ptr <= '0;
            if (out_room) begin
               pack_a <= '0;
               pack_b <= '0;
            end else begin
               pack_a     <= close_a;
               pack_b     <= close_b;
               pack_count <= close_count;
               pack_last  <= in_last;
               pack_full  <= 1'b1;
            end
         end else begin
            pack_a[`LANE(ptr)] <= in_a;
            pack_b[`LANE(ptr)] <= in_b;
            ptr                <= ptr + PW'(1);
         end
      end
   end

   vec_skid_reg #(
      .W (PAYLOAD_W)
   ) u_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (out_push),
      .in_ready  (out_room),
      .in_data   (out_push_data),
      .out_valid (vec_valid),
      .out_ready (vec_ready),
      .out_data  (out_data)
   );

   assign {vec_a, vec_b, vec_count, vec_last} = out_data;

endmodule
